// File: rtl/paddle_cmd_encoder_pkg.sv
// Shared types and default parameters for the paddle command encoder.
package paddle_cmd_encoder_pkg;

    // Command word consumed by the paddle mover; 2'h3 is never produced.
    typedef enum logic [1:0] {
        PUT   = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } paddle_cmd_t;

    // Direction FSM states; encodings line up with paddle_cmd_t.
    typedef enum logic [1:0] {
        S_PUT   = 2'd0,
        S_LEFT  = 2'd1,
        S_RIGHT = 2'd2
    } dir_state_t;

    // Stable clk cycles required before a button level is accepted.
    localparam int DEBOUNCE_CYCLES = 250_000;

    // frame_ticks after the game_over rise before a restart press is honoured.
    localparam int RESTART_PAUSE = 128;

    // Map a direction state onto the command word it publishes.
    function automatic paddle_cmd_t state_to_cmd(input dir_state_t s);
        paddle_cmd_t c;
        case (s)
            S_LEFT:  c = LEFT;
            S_RIGHT: c = RIGHT;
            default: c = PUT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/paddle_cmd_encoder_if.sv
// Command link between the encoder (master) and the game logic (slave).
// There is no ready: the slave must accept paddle_cmd on every cycle where
// cmd_strobe is high, and restart_req is a single-cycle request that is
// never held or repeated. frame_tick and game_over flow back to the encoder.
interface paddle_cmd_encoder_if;
    import paddle_cmd_encoder_pkg::*;

    logic        frame_tick;
    logic        game_over;
    paddle_cmd_t paddle_cmd;
    logic        cmd_strobe;
    logic        restart_req;

    modport master (
        input  frame_tick,
        input  game_over,
        output paddle_cmd,
        output cmd_strobe,
        output restart_req
    );

    modport slave (
        output frame_tick,
        output game_over,
        input  paddle_cmd,
        input  cmd_strobe,
        input  restart_req
    );

endinterface

// File: rtl/paddle_cmd_encoder_btn_debounce.sv
// Synchronise one raw push-button, debounce it and produce a rise pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = paddle_cmd_encoder_pkg::DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_1;
    logic             sync_2;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser, then accept the new level only after it has
    // disagreed with the accepted level for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync_1   <= btn;
            sync_2   <= sync_1;
            stable_d <= stable;
            if (sync_2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync_2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign rise = stable & ~stable_d;

endmodule

// File: rtl/paddle_cmd_encoder.sv
// Turns board push-buttons into one paddle command per frame and issues the
// restart request after game over. Single clock (pixel clock) domain.
module paddle_cmd_encoder #(
    parameter int DEBOUNCE_CYCLES = paddle_cmd_encoder_pkg::DEBOUNCE_CYCLES,
    parameter int RESTART_PAUSE   = paddle_cmd_encoder_pkg::RESTART_PAUSE
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               btn_left_i,
    input  logic                               btn_right_i,
    input  logic                               btn_center_i,
    paddle_cmd_encoder_if.master               bus,
    output logic [1:0]                         dbg_state,
    output logic [2:0]                         dbg_stable,
    output logic [$clog2(RESTART_PAUSE+1)-1:0] dbg_pause_cnt
);

    import paddle_cmd_encoder_pkg::*;

    localparam int PAUSE_W = $clog2(RESTART_PAUSE + 1);

    logic stable_l, rise_l;
    logic stable_r, rise_r;
    logic stable_c, rise_c;

    dir_state_t         state;
    dir_state_t         state_next;
    logic               game_over_d;
    logic [PAUSE_W-1:0] pause_cnt;
    logic               go_rise;
    logic               pause_done;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .clk(clk), .rst_n(rst_n), .btn(btn_left_i), .stable(stable_l), .rise(rise_l)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .clk(clk), .rst_n(rst_n), .btn(btn_right_i), .stable(stable_r), .rise(rise_r)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_center (
        .clk(clk), .rst_n(rst_n), .btn(btn_center_i), .stable(stable_c), .rise(rise_c)
    );

    // Direction state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_PUT;
        end else begin
            state <= state_next;
        end
    end

    // Last-pressed-wins: a fresh press overrides, a simultaneous pair cancels,
    // and a release falls back to whatever is still held.
    always_comb begin
        state_next = state;
        if (rise_l && rise_r) begin
            state_next = S_PUT;
        end else if (rise_l) begin
            state_next = S_LEFT;
        end else if (rise_r) begin
            state_next = S_RIGHT;
        end else begin
            case (state)
                S_LEFT: begin
                    if (!stable_l) state_next = stable_r ? S_RIGHT : S_PUT;
                end
                S_RIGHT: begin
                    if (!stable_r) state_next = stable_l ? S_LEFT : S_PUT;
                end
                S_PUT: begin
                    if (stable_l && !stable_r)      state_next = S_LEFT;
                    else if (stable_r && !stable_l) state_next = S_RIGHT;
                end
                default: state_next = S_PUT;
            endcase
        end
    end

    // Publish the current (pre-transition) state once per frame; game over
    // parks the paddle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.paddle_cmd <= PUT;
            bus.cmd_strobe <= 1'b0;
        end else begin
            bus.cmd_strobe <= bus.frame_tick;
            if (bus.frame_tick) begin
                bus.paddle_cmd <= bus.game_over ? PUT : state_to_cmd(state);
            end
        end
    end

    assign go_rise    = bus.game_over & ~game_over_d;
    assign pause_done = (pause_cnt == PAUSE_W'(RESTART_PAUSE));

    // Count frames since game over began; only honour a restart press once
    // the pause has elapsed. Earlier presses are simply lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            game_over_d     <= 1'b0;
            pause_cnt       <= '0;
            bus.restart_req <= 1'b0;
        end else begin
            game_over_d     <= bus.game_over;
            bus.restart_req <= rise_c & bus.game_over & pause_done;
            if (go_rise) begin
                pause_cnt <= '0;
            end else if (bus.frame_tick && bus.game_over && !pause_done) begin
                pause_cnt <= pause_cnt + PAUSE_W'(1);
            end
        end
    end

    assign dbg_state     = state;
    assign dbg_stable    = {stable_c, stable_r, stable_l};
    assign dbg_pause_cnt = pause_cnt;

endmodule

// File: tb/tb_paddle_cmd_encoder.sv
// Directed bench for paddle_cmd_encoder with short debounce and pause.
module tb_paddle_cmd_encoder;
    import paddle_cmd_encoder_pkg::*;

    localparam int DEB   = 4;
    localparam int PAUSE = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_l = 1'b0;
    logic       btn_r = 1'b0;
    logic       btn_c = 1'b0;
    logic [1:0] dbg_state;
    logic [2:0] dbg_stable;
    logic [3:0] dbg_pause_cnt;

    int checks = 0;
    int failures = 0;
    int viol = 0;
    logic tick_prev = 1'b0;
    logic restart_prev = 1'b0;
    logic [31:0] exp_q[$];

    paddle_cmd_encoder_if bus();

    paddle_cmd_encoder #(.DEBOUNCE_CYCLES(DEB), .RESTART_PAUSE(PAUSE)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_left_i(btn_l),
        .btn_right_i(btn_r),
        .btn_center_i(btn_c),
        .bus(bus.master),
        .dbg_state(dbg_state),
        .dbg_stable(dbg_stable),
        .dbg_pause_cnt(dbg_pause_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    // Free-running frame tick: one cycle high every 50 clk.
    initial begin
        bus.frame_tick = 1'b0;
        forever begin
            repeat (49) @(posedge clk);
            #1 bus.frame_tick = 1'b1;
            @(posedge clk);
            #1 bus.frame_tick = 1'b0;
        end
    end

    // Invariant monitor: no 2'h3, strobe only after a tick, restart never doubled.
    always @(negedge clk) begin
        if (bus.paddle_cmd == 2'd3) viol++;
        if (bus.cmd_strobe && !tick_prev) viol++;
        if (bus.restart_req && restart_prev) viol++;
        tick_prev    = bus.frame_tick;
        restart_prev = bus.restart_req;
    end

    // Watchdog
    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance n posedges, then sit 1 time unit past the edge to drive inputs.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the next cmd_strobe, compare the command, and make
    // sure the strobe lasts a single cycle.
    task automatic wait_strobe(input string tag, input logic [1:0] exp);
        bit found = 0;
        exp_q.push_back(32'(exp));
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (bus.cmd_strobe) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end else begin
            check(tag, 32'(bus.paddle_cmd), exp_q.pop_front());
            @(negedge clk);
            check({tag, "_strobe_len"}, 32'(bus.cmd_strobe), 32'd0);
        end
    endtask

    // Let n frames go by without checking the command.
    task automatic skip_strobes(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            bit found = 0;
            for (int i = 0; i < 120; i++) begin
                @(negedge clk);
                if (bus.cmd_strobe) begin
                    found = 1;
                    break;
                end
            end
            if (!found) check({tag, "_timeout"}, 32'd0, 32'd1);
        end
    endtask

    // Observe restart_req for n cycles: number of pulses and longest run.
    task automatic watch_restart(input int n, output int pulses, output int max_run);
        int run = 0;
        pulses  = 0;
        max_run = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.restart_req) begin
                if (run == 0) pulses++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
    endtask

    initial begin
        int pulses;
        int max_run;
        bit aligned;

        bus.game_over = 1'b0;

        // Reset state
        step(3);
        @(negedge clk);
        check("rst_cmd", 32'(bus.paddle_cmd), 32'(PUT));
        check("rst_strobe", 32'(bus.cmd_strobe), 32'd0);
        check("rst_restart", 32'(bus.restart_req), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(S_PUT));
        check("rst_pause", 32'(dbg_pause_cnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(2);

        // Bounce on left, then a clean hold
        for (int i = 0; i < 10; i++) begin
            btn_l = (i % 2 == 0);
            step(2);
        end
        check("bounce_stable_during", 32'(dbg_stable[0]), 32'd0);
        btn_l = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("bounce_stable_edge5", 32'(dbg_stable[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("bounce_stable_edge6", 32'(dbg_stable[0]), 32'd1);
        check("bounce_state_pre", 32'(dbg_state), 32'(S_PUT));
        @(posedge clk);
        @(negedge clk);
        check("bounce_state", 32'(dbg_state), 32'(S_LEFT));
        wait_strobe("bounce_cmd", 2'd1);

        // Last pressed wins
        step(1);
        btn_r = 1'b1;
        step(10);
        wait_strobe("lp_right", 2'd2);
        step(1);
        btn_r = 1'b0;
        step(10);
        wait_strobe("lp_back_left", 2'd1);
        step(1);
        btn_l = 1'b0;
        step(10);
        wait_strobe("lp_release", 2'd0);

        // Tie cancels
        step(1);
        btn_l = 1'b1;
        btn_r = 1'b1;
        step(10);
        check("tie_state", 32'(dbg_state), 32'(S_PUT));
        wait_strobe("tie_1", 2'd0);
        wait_strobe("tie_2", 2'd0);
        step(1);
        btn_r = 1'b0;
        step(10);
        wait_strobe("tie_release_r", 2'd1);

        // Game over with restart pause
        step(1);
        bus.game_over = 1'b1;
        wait_strobe("go_cmd", 2'd0);
        skip_strobes("go_skip3", 2);
        check("go_pause3", 32'(dbg_pause_cnt), 32'd3);
        step(1);
        btn_c = 1'b1;
        watch_restart(20, pulses, max_run);
        check("go_early_restart", 32'(pulses), 32'd0);
        step(1);
        btn_c = 1'b0;
        step(10);
        skip_strobes("go_skip_sat", 6);
        check("go_pause_sat", 32'(dbg_pause_cnt), 32'(PAUSE));
        step(1);
        btn_c = 1'b1;
        watch_restart(20, pulses, max_run);
        check("go_restart_pulses", 32'(pulses), 32'd1);
        check("go_restart_width", 32'(max_run), 32'd1);
        step(1);
        btn_c = 1'b0;
        step(10);

        // Drop game_over in the same cycle as a frame tick
        aligned = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #2;
            if (bus.frame_tick) begin
                bus.game_over = 1'b0;
                aligned = 1;
                break;
            end
        end
        if (!aligned) check("go_align_timeout", 32'd0, 32'd1);
        wait_strobe("go_drop_same_tick", 2'd1);

        // Centre press while playing does nothing
        step(1);
        btn_c = 1'b1;
        watch_restart(20, pulses, max_run);
        check("play_no_restart", 32'(pulses), 32'd0);
        step(1);
        btn_c = 1'b0;

        // Reset in the middle of operation
        btn_l = 1'b0;
        btn_r = 1'b1;
        step(10);
        wait_strobe("rst_pre_cmd", 2'd2);
        step(1);
        bus.game_over = 1'b1;
        skip_strobes("rst_skip5", 5);
        check("rst_pre_pause", 32'(dbg_pause_cnt), 32'd5);
        check("rst_pre_state", 32'(dbg_state), 32'(S_RIGHT));
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_cmd", 32'(bus.paddle_cmd), 32'(PUT));
        check("mid_rst_strobe", 32'(bus.cmd_strobe), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(S_PUT));
        check("mid_rst_pause", 32'(dbg_pause_cnt), 32'd0);
        skip_strobes("rst_post1", 1);
        check("rst_post_pause1", 32'(dbg_pause_cnt), 32'd1);
        step(1);
        bus.game_over = 1'b0;
        btn_r = 1'b0;
        step(5);
        bus.game_over = 1'b1;
        step(1);
        @(negedge clk);
        check("rst_rego_clear", 32'(dbg_pause_cnt), 32'd0);
        skip_strobes("rst_rego2", 2);
        check("rst_rego_pause2", 32'(dbg_pause_cnt), 32'd2);

        check("invariants", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
